// File: rtl/reg_file.sv
// Integer register file with pending-write scoreboard for decode hazards.
// Define REGFILE_BYPASS_EN for same-cycle writeback-to-read forwarding.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_wen,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            sb_set,
  input  logic [4:0]      sb_rd,
  output logic            rs1_pending,
  output logic            rs2_pending,
  output logic [5:0]      pending_cnt
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_sb;
  logic [5:0]      r_cnt;

  logic            w_wr;
  logic            w_set;
  logic [NREG-1:0] w_sb_next;
  logic [5:0]      w_cnt_next;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic            w_pd1;
  logic            w_pd2;

  assign w_wr  = wb_wen && (wb_addr != 5'd0);
  assign w_set = sb_set && (sb_rd != 5'd0);

  // Set is applied after clear so a re-issued producer keeps its bit.
  always_comb begin
    w_sb_next = r_sb;
    if (w_wr)
      w_sb_next[wb_addr] = 1'b0;
    if (w_set)
      w_sb_next[sb_rd] = 1'b1;
  end

  always_comb begin
    w_cnt_next = 6'd0;
    for (int i = 1; i < NREG; i++)
      w_cnt_next = w_cnt_next + 6'(w_sb_next[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_sb  <= '0;
      r_cnt <= 6'd0;
    end else begin
      if (w_wr)
        r_regs[wb_addr] <= wb_data;
      r_sb  <= w_sb_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign w_rd1 = (rs1_addr == 5'd0) ? '0 : r_regs[rs1_addr];
  assign w_rd2 = (rs2_addr == 5'd0) ? '0 : r_regs[rs2_addr];
  assign w_pd1 = (rs1_addr != 5'd0) && r_sb[rs1_addr];
  assign w_pd2 = (rs2_addr != 5'd0) && r_sb[rs2_addr];

`ifdef REGFILE_BYPASS_EN
  logic w_fw1;
  logic w_fw2;

  assign w_fw1 = w_wr && (wb_addr == rs1_addr);
  assign w_fw2 = w_wr && (wb_addr == rs2_addr);

  // A forwarded source is only pending if a new producer claims it now.
  assign rs1_data    = w_fw1 ? wb_data : w_rd1;
  assign rs2_data    = w_fw2 ? wb_data : w_rd2;
  assign rs1_pending = w_fw1 ? (w_set && (sb_rd == rs1_addr)) : w_pd1;
  assign rs2_pending = w_fw2 ? (w_set && (sb_rd == rs2_addr)) : w_pd2;
`else
  assign rs1_data    = w_rd1;
  assign rs2_data    = w_rd2;
  assign rs1_pending = w_pd1;
  assign rs2_pending = w_pd2;
`endif

  assign pending_cnt = r_cnt;

endmodule
